// File: rtl/draw_controller_if.sv
// draw_controller_if: sprite move requests in, frame-buffer pixel writes out.
//   master : sprite controllers / test driver (drives clear, *_move, coords)
//   slave  : draw_controller (drives x_out, y_out, colour, plot, busy)
interface draw_controller_if;
  logic       clear;
  logic       player_move;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic       enemy_move;
  logic [7:0] enemy_x;
  logic [6:0] enemy_y;
  logic [2:0] enemy_width;
  logic [2:0] enemy_color;
  logic       bullet_move;
  logic [7:0] bullet_x;
  logic [6:0] bullet_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  modport master (
    output clear, player_move, player_x, player_y,
           enemy_move, enemy_x, enemy_y, enemy_width, enemy_color,
           bullet_move, bullet_x, bullet_y,
    input  x_out, y_out, colour, plot, busy
  );

  modport slave (
    input  clear, player_move, player_x, player_y,
           enemy_move, enemy_x, enemy_y, enemy_width, enemy_color,
           bullet_move, bullet_x, bullet_y,
    output x_out, y_out, colour, plot, busy
  );
endinterface

// File: rtl/draw_controller.sv
// draw_controller: pixel-serial sprite renderer feeding the VGA frame buffer.
// Captures player/enemy/bullet move pulses, erases each sprite's previous
// square in background colour, redraws it at the new position (one pixel per
// clock), and runs full-screen clears after reset and on level load.
// Ports:
//   clk    : system clock
//   resetn : synchronous active-low reset (starts a full clear)
//   bus    : draw_controller_if.slave (requests in, pixel writes out)
module draw_controller #(
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 121,
  parameter logic [2:0]  PLAYER_W     = 3'd3,
  parameter logic [2:0]  PLAYER_COLOR = 3'b010,
  parameter logic [2:0]  BULLET_COLOR = 3'b100,
  parameter logic [2:0]  BG_COLOR     = 3'b000
) (
  input  logic              clk,
  input  logic              resetn,
  draw_controller_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, ERASE, DRAW, CLEAR} state_t;

  typedef struct packed {
    logic       v;
    logic [2:0] w;
    logic [6:0] y;
    logic [7:0] x;
  } shadow_t;

  localparam logic [1:0] S_P = 2'd0, S_E = 2'd1, S_B = 2'd2;
  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  state_t          state;
  logic [1:0]      sel;
  shadow_t [2:0]   sh;
  logic [7:0]      lx;
  logic [6:0]      ly;
  logic [2:0]      lw, lc;
  logic [7:0]      dx;
  logic [6:0]      dy;
  logic [2:0]      pend;
  logic            clear_req;

  // Current square base/size: ERASE walks the shadow, DRAW the latched job.
  logic [7:0] bx;
  logic [6:0] by;
  logic [2:0] bw, wm1, sel_oh, pend_clr, pend_set;
  logic [8:0] px;
  logic [7:0] py;
  logic       on_screen, last, clear_done;

  always_comb begin
    bx         = (state == ERASE) ? sh[sel].x : lx;
    by         = (state == ERASE) ? sh[sel].y : ly;
    bw         = (state == ERASE) ? sh[sel].w : lw;
    wm1        = bw - 3'd1;
    px         = {1'b0, bx} + {1'b0, dx};
    py         = {1'b0, by} + {1'b0, dy};
    on_screen  = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
    last       = (dx == {5'd0, wm1}) && (dy == {4'd0, wm1});
    clear_done = (state == CLEAR) && (dx == X_LAST) && (dy == Y_LAST);
    sel_oh     = 3'b001 << sel;
    // An abort keeps the flag, so LOAD only consumes it when clear is low.
    pend_clr   = (state == LOAD && !bus.clear) ? sel_oh : 3'b000;
    pend_set   = {bus.bullet_move, bus.enemy_move, bus.player_move};
    if (bus.clear && (state == LOAD || state == ERASE || state == DRAW))
      pend_set = pend_set | sel_oh;
    if (clear_done)
      pend_set = 3'b111;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= CLEAR;
      sel        <= S_P;
      sh         <= '0;
      lx         <= '0;
      ly         <= '0;
      lw         <= '0;
      lc         <= BG_COLOR;
      dx         <= '0;
      dy         <= '0;
      pend       <= '0;
      clear_req  <= 1'b0;
      bus.x_out  <= '0;
      bus.y_out  <= '0;
      bus.colour <= BG_COLOR;
      bus.plot   <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      pend     <= (pend & ~pend_clr) | pend_set;
      bus.plot <= 1'b0;
      bus.busy <= (state != IDLE);
      case (state)
        IDLE: begin
          if (clear_req) begin
            state     <= CLEAR;
            dx        <= '0;
            dy        <= '0;
            clear_req <= 1'b0;
          end else if (pend[0]) begin
            sel <= S_P; state <= LOAD;
          end else if (pend[1]) begin
            sel <= S_E; state <= LOAD;
          end else if (pend[2]) begin
            sel <= S_B; state <= LOAD;
          end
        end
        LOAD: begin
          case (sel)
            S_E: begin
              lx <= bus.enemy_x;  ly <= bus.enemy_y;
              lw <= bus.enemy_width; lc <= bus.enemy_color;
            end
            S_B: begin
              lx <= bus.bullet_x; ly <= bus.bullet_y;
              lw <= 3'd1; lc <= BULLET_COLOR;
            end
            default: begin
              lx <= bus.player_x; ly <= bus.player_y;
              lw <= PLAYER_W; lc <= PLAYER_COLOR;
            end
          endcase
          dx    <= '0;
          dy    <= '0;
          state <= (sh[sel].v && sh[sel].w != 3'd0) ? ERASE : DRAW;
        end
        ERASE, DRAW: begin
          bus.x_out  <= px[7:0];
          bus.y_out  <= py[6:0];
          bus.colour <= (state == ERASE) ? BG_COLOR : lc;
          // Off-screen pixels still take their cycle, just without a write.
          bus.plot   <= on_screen && (bw != 3'd0);
          if (bw == 3'd0 || last) begin
            dx <= '0;
            dy <= '0;
            if (state == ERASE) begin
              state <= DRAW;
            end else begin
              sh[sel] <= '{v: 1'b1, w: lw, y: ly, x: lx};
              state   <= IDLE;
            end
          end else if (dx == {5'd0, wm1}) begin
            dx <= '0;
            dy <= dy + 7'd1;
          end else begin
            dx <= dx + 8'd1;
          end
        end
        CLEAR: begin
          bus.x_out  <= dx;
          bus.y_out  <= dy;
          bus.colour <= BG_COLOR;
          bus.plot   <= 1'b1;
          // A clear during a clear is remembered and run again afterwards.
          if (bus.clear) clear_req <= 1'b1;
          if (clear_done) begin
            dx <= '0;
            dy <= '0;
            for (int i = 0; i < 3; i++) sh[i].v <= 1'b0;
            state <= IDLE;
          end else if (dx == X_LAST) begin
            dx <= '0;
            dy <= dy + 7'd1;
          end else begin
            dx <= dx + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
      // Level load preempts any job on the very next edge.
      if (bus.clear && state != CLEAR) begin
        state     <= CLEAR;
        dx        <= '0;
        dy        <= '0;
        clear_req <= 1'b0;
      end
    end
  end

endmodule

// File: doc/draw_controller.md
# draw_controller

Pixel-serial renderer sitting directly downstream of the player, enemy and bullet controllers and upstream of the VGA adapter. It captures each sprite's one-cycle `move` pulse together with its coordinates, erases the sprite's previously drawn square in background colour, then draws it at the new position, one pixel per clock. It also performs full-screen clears on reset and level load. Its x/y/colour/plot outputs connect straight to the frame-buffer write port.

## Interface
- `SCREEN_W`, 160, visible columns; pixels with x ≥ SCREEN_W are suppressed
- `SCREEN_H`, 121, visible rows; pixels with y ≥ SCREEN_H are suppressed
- `PLAYER_W`, 3, player square side in pixels
- `PLAYER_COLOR`, 3'b010, player colour
- `BULLET_COLOR`, 3'b100, bullet colour (bullet is 1×1)
- `BG_COLOR`, 3'b000, erase/clear colour
- `clk`  in  1  system clock
- `resetn`  in  1  reset, synchronous, active-low
- `clear`  in  1  level-load pulse; requests a full-screen clear
- `player_move`  in  1  one-cycle pulse: player moved
- `player_x` / `player_y`  in  8 / 7  player top-left pixel
- `enemy_move`  in  1  one-cycle pulse: enemy moved
- `enemy_x` / `enemy_y`  in  8 / 7  enemy top-left pixel
- `enemy_width`  in  3  enemy side in pixels (0 = nothing drawn)
- `enemy_color`  in  3  enemy colour
- `bullet_move`  in  1  one-cycle pulse: bullet moved
- `bullet_x` / `bullet_y`  in  8 / 7  bullet pixel
- `x_out` / `y_out`  out  8 / 7  pixel coordinate (registered)
- `colour`  out  3  pixel colour (registered)
- `plot`  out  1  write strobe; pixel valid when high
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- Pending flags `pend_p`, `pend_e`, `pend_b`: set by the matching move pulse and held until serviced. A pulse arriving in the same cycle the flag is cleared leaves the flag set.
- `clear_req` is set by `clear` and held until CLEAR starts.
- Per-sprite shadow registers hold the last drawn x, y, width and a valid bit. The enemy shadow width comes from `enemy_width` at draw time. The player shadow width is PLAYER_W and the bullet shadow width is 1.
- States are IDLE, LOAD, ERASE, DRAW and CLEAR.
- Selection priority, evaluated in IDLE: clear_req > pend_p > pend_e > pend_b.
- **LOAD** (1 cycle, plot=0):
  - clears the selected pending flag
  - latches the new x, y, width and colour from the inputs
  - zeroes counters dx and dy
  - next state is ERASE if the shadow is valid and its width is nonzero, otherwise DRAW
- **ERASE**: walks the shadow square with dx inner (0..w−1) and dy outer, emitting (shadow_x+dx, shadow_y+dy) in BG_COLOR. After the last pixel it goes to DRAW with counters zeroed.
- **DRAW**: walks the latched square the same way in the sprite colour. On the last pixel it updates the shadow from the latched values, sets valid, and goes to IDLE. Width 0 means DRAW lasts 1 cycle with plot=0 and valid set.
- Coordinate sums are computed 9/8 bits wide. A pixel outside the screen still consumes its cycle but has plot=0.
- **CLEAR**: raster over x 0..159 (inner) and y 0..120 (outer) in BG_COLOR, 19,360 cycles. On the last pixel it clears all valid bits, sets all three pending flags, and goes to IDLE.
- `clear` asserted in any state aborts the current job on the next edge and enters CLEAR. The aborted sprite's pending flag is re-set.
- Reset: state=CLEAR with counters 0, valid bits 0, pending flags 0, x_out=0, y_out=0, colour=BG_COLOR, plot=0, busy=0. Reset therefore always starts with a full clear.

## Timing
- Outputs are registered. The pixel for counter state k appears the cycle after the state/counter edge.
- Per job: 1 (LOAD) + w_old² (ERASE, if valid) + w_new² (DRAW) cycles, then 1 IDLE cycle before the next selection.
- Player job with valid shadow: 1+9+9 = 19 cycles. Bullet job: 3 cycles. Enemy width 4: 33 cycles.
- First plot after resetn rises: the cycle after the first active edge, at (0,0).
- Move pulses are never lost, but multiple pulses for one sprite before service coalesce into one job using the coordinates at LOAD.

## Test plan
- **Reset/clear**: hold resetn=0 for 2 cycles, release → exactly 19,360 plot=1 cycles in BG from (0,0) to (159,120), busy high. Then player, enemy and bullet each drawn once with no ERASE (9, w², 1 pixels).
- **Player move**: player shadow valid at (80,115); pulse player_move with player_x=79 → erase 9 pixels (80..82, 115..117) in 000, then draw 9 pixels (79..81, 115..117) in 010, total 19 cycles.
- **Simultaneous pulses**: player_move, enemy_move (width 4) and bullet_move in the same cycle → service order player, enemy, bullet. Cycle counts 19, 33, 3 separated by single IDLE cycles.
- **Clipping**: enemy at x=158, width 4 → only x=158,159 plotted per row (8 plot pulses of 16 DRAW cycles). No pixel with x ≥ 160.
- **Clear mid-job**: assert clear during player ERASE → CLEAR starts next cycle; after 19,360 pixels all three sprites are redrawn without erase.
- **Pulse during busy**: bullet_move pulses twice during an enemy job → exactly one bullet job afterwards, at the latest bullet coordinates.
